// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state encoding, opcode/funct constants and control-word encodings for multicycle_ctrl
// ST_EXC exists only when OVERFLOW_EXC_EN is defined.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET      = 4'd0,
        ST_FETCH      = 4'd1,
        ST_FETCH_WAIT = 4'd2,
        ST_DECODE     = 4'd3,
        ST_EXEC_R     = 4'd4,
        ST_WB_R       = 4'd5,
        ST_EXEC_I     = 4'd6,
        ST_WB_I       = 4'd7,
        ST_ADDR       = 4'd8,
        ST_MEM_RD     = 4'd9,
        ST_MEM_WAIT   = 4'd10,
        ST_WB_LOAD    = 4'd11,
        ST_MEM_WR     = 4'd12,
        ST_BRANCH     = 4'd13,
        ST_JUMP       = 4'd14
`ifdef OVERFLOW_EXC_EN
        ,
        ST_EXC        = 4'd15
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [1:0] SRCA_PC  = 2'b00;
    localparam logic [1:0] SRCA_A   = 2'b01;
    localparam logic [1:0] SRCA_B   = 2'b10;
    // MDR operand is reserved; nothing in the base instruction set selects it.
    localparam logic [1:0] SRCA_MDR = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    typedef struct packed {
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       epc_write;
    } ctrl_word_t;

    function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// rtl/ctrl_outdec.sv - decodes the registered state (and funct in EXEC_R) into the control word
// EPCWrite is only ever asserted when OVERFLOW_EXC_EN is defined.
module ctrl_outdec
    import ctrl_pkg::*;
(
    input  state_e     state_q,
    input  logic [5:0] funct,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b0;
            end
            ST_FETCH_WAIT: begin
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_ALU;
            end
            // Branch target is precomputed here while the opcode is dispatched.
            ST_DECODE: begin
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = funct_alu_op(funct);
            end
            ST_WB_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            ST_EXEC_I, ST_ADDR: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_WB_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b0;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_WB_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            // zero gates PCWriteCond in the PC datapath, not here.
            ST_BRANCH: begin
                ctrl.alu_src_a     = SRCA_A;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef OVERFLOW_EXC_EN
            ST_EXC: begin
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_SUB;
                ctrl.epc_write = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_EXC;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM: state register and next-state logic
// OVERFLOW_EXC_EN adds the EXC state for overflow and unknown opcodes.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       EPCWrite,
    output logic [1:0] PCSource,
    output logic [3:0] state
);

    state_e     state_q, state_d;
    logic       is_store_q, is_store_d;
    ctrl_word_t ctrl;

    // zero is consumed by the PC datapath; overflow only matters with exceptions enabled.
    logic unused_inputs;
    assign unused_inputs = zero ^ overflow;

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        case (state_q)
            ST_RESET:      state_d = ST_FETCH;
            ST_FETCH:      state_d = ST_FETCH_WAIT;
            ST_FETCH_WAIT: state_d = ST_DECODE;
            // Load/store choice is latched so ADDR never looks at opcode again.
            ST_DECODE: begin
                is_store_d = (opcode == OP_SW);
                case (opcode)
                    OP_RTYPE:     state_d = ST_EXEC_R;
                    OP_LW, OP_SW: state_d = ST_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_EXEC_I;
`ifdef OVERFLOW_EXC_EN
                    default:      state_d = ST_EXC;
`else
                    default:      state_d = ST_FETCH;
`endif
                endcase
            end
            ST_EXEC_R: begin
`ifdef OVERFLOW_EXC_EN
                if (overflow && (funct_alu_op(funct) != ALU_AND)) state_d = ST_EXC;
                else                                              state_d = ST_WB_R;
`else
                state_d = ST_WB_R;
`endif
            end
            ST_EXEC_I: begin
`ifdef OVERFLOW_EXC_EN
                state_d = overflow ? ST_EXC : ST_WB_I;
`else
                state_d = ST_WB_I;
`endif
            end
            ST_ADDR:     state_d = is_store_q ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: state_d = ST_WB_LOAD;
            default:     state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
        end
    end

    ctrl_outdec u_outdec (
        .state_q (state_q),
        .funct   (funct),
        .ctrl    (ctrl)
    );

    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegWrite    = ctrl.reg_write;
    assign MemToReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign EPCWrite    = ctrl.epc_write;
    assign PCSource    = ctrl.pc_source;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl; honours OVERFLOW_EXC_EN
module tb_multicycle_ctrl;

`ifdef OVERFLOW_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, overflow;
    logic [1:0] ALUSrcA, ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegWrite, MemToReg, RegDst, EPCWrite;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .EPCWrite(EPCWrite), .PCSource(PCSource), .state(state)
    );

    always #5 clk = ~clk;

    logic [18:0] dut_ctrl;
    assign dut_ctrl = {ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond, IorD,
                       MemRead, MemWrite, IRWrite, RegWrite, MemToReg, RegDst, EPCWrite};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [3:0] st;
        logic [5:0] op;
        logic [5:0] fn;
        logic       ovf;
        logic       zr;
        string      tag;
    } step_t;

    step_t sb[$];

    // Reference control word per state, written straight from the state table.
    function automatic logic [18:0] exp_ctrl(input logic [3:0] st, input logic [5:0] fn);
        logic [1:0] asa, asb, pcs;
        logic [2:0] op;
        logic pcw, pcwc, iord, mrd, mwr, irw, rw, m2r, rdst, epc;
        asa = 2'b00; asb = 2'b00; pcs = 2'b00; op = 3'b000;
        pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; m2r = 0; rdst = 0; epc = 0;
        case (st)
            4'd1:  mrd = 1;
            4'd2:  begin irw = 1; asb = 2'b01; pcw = 1; end
            4'd3:  asb = 2'b11;
            4'd4:  begin asa = 2'b01; op = (fn == 6'h22) ? 3'b001 : (fn == 6'h24) ? 3'b010 : 3'b000; end
            4'd5:  begin rw = 1; rdst = 1; end
            4'd6:  begin asa = 2'b01; asb = 2'b10; end
            4'd7:  rw = 1;
            4'd8:  begin asa = 2'b01; asb = 2'b10; end
            4'd9:  begin mrd = 1; iord = 1; end
            4'd11: begin rw = 1; m2r = 1; end
            4'd12: begin mwr = 1; iord = 1; end
            4'd13: begin asa = 2'b01; op = 3'b001; pcwc = 1; pcs = 2'b01; end
            4'd14: begin pcw = 1; pcs = 2'b10; end
            4'd15: begin asb = 2'b01; op = 3'b001; epc = 1; pcw = 1; pcs = 2'b11; end
            default: ;
        endcase
        return {asa, asb, op, pcs, pcw, pcwc, iord, mrd, mwr, irw, rw, m2r, rdst, epc};
    endfunction

    task automatic push(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn,
                        input logic ovf, input logic zr, input string tag);
        step_t e;
        e.st = st; e.op = op; e.fn = fn; e.ovf = ovf; e.zr = zr; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn,
                              input logic ovf, input logic zr, input string tag);
        push(4'd1, op, fn, ovf, zr, tag);
        push(4'd2, op, fn, ovf, zr, tag);
        push(4'd3, op, fn, ovf, zr, tag);
        case (op)
            6'h00: begin
                push(4'd4, op, fn, ovf, zr, tag);
                push((EXC_EN && ovf && fn != 6'h24) ? 4'd15 : 4'd5, op, fn, ovf, zr, tag);
            end
            6'h08: begin
                push(4'd6, op, fn, ovf, zr, tag);
                push((EXC_EN && ovf) ? 4'd15 : 4'd7, op, fn, ovf, zr, tag);
            end
            6'h23: begin
                push(4'd8, op, fn, ovf, zr, tag);
                push(4'd9, op, fn, ovf, zr, tag);
                push(4'd10, op, fn, ovf, zr, tag);
                push(4'd11, op, fn, ovf, zr, tag);
            end
            6'h2B: begin
                push(4'd8, op, fn, ovf, zr, tag);
                push(4'd12, op, fn, ovf, zr, tag);
            end
            6'h04: push(4'd13, op, fn, ovf, zr, tag);
            6'h02: push(4'd14, op, fn, ovf, zr, tag);
            default: if (EXC_EN) push(4'd15, op, fn, ovf, zr, tag);
        endcase
    endtask

    // Real opcode/funct only where the FSM may sample them; noise everywhere else.
    task automatic drain();
        while (sb.size() > 0) begin
            step_t e;
            e = sb.pop_front();
            @(negedge clk);
            opcode   = (e.st == 4'd3) ? e.op : 6'($urandom);
            funct    = (e.st == 4'd4) ? e.fn : 6'($urandom);
            overflow = (e.st == 4'd4 || e.st == 4'd6) ? e.ovf : 1'($urandom);
            zero     = (e.st == 4'd13) ? e.zr : 1'($urandom);
            #1;
            check($sformatf("%s/state_s%0d", e.tag, e.st), 32'(state), 32'(e.st));
            check($sformatf("%s/ctrl_s%0d", e.tag, e.st), 32'(dut_ctrl), 32'(exp_ctrl(e.st, e.fn)));
        end
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset/state", 32'(state), 32'd0);
        check("reset/ctrl", 32'(dut_ctrl), 32'd0);
        reset = 1'b0;

        push_instr(6'h00, 6'h20, 1'b0, 1'b0, "r_add");
        push_instr(6'h00, 6'h22, 1'b0, 1'b0, "r_sub");
        push_instr(6'h00, 6'h24, 1'b0, 1'b0, "r_and");
        push_instr(6'h00, 6'h2A, 1'b0, 1'b0, "r_other");
        push_instr(6'h23, 6'h00, 1'b0, 1'b0, "lw");
        push_instr(6'h2B, 6'h00, 1'b0, 1'b0, "sw");
        push_instr(6'h04, 6'h00, 1'b0, 1'b0, "beq_z0");
        push_instr(6'h04, 6'h00, 1'b0, 1'b1, "beq_z1");
        push_instr(6'h02, 6'h00, 1'b0, 1'b0, "j");
        push_instr(6'h08, 6'h00, 1'b0, 1'b0, "addi");
        push_instr(6'h08, 6'h00, 1'b1, 1'b0, "addi_ovf");
        push_instr(6'h00, 6'h22, 1'b1, 1'b0, "r_sub_ovf");
        push_instr(6'h00, 6'h24, 1'b1, 1'b0, "r_and_ovf");
        push_instr(6'h3F, 6'h00, 1'b0, 1'b0, "bad_op");
        push_instr(6'h2B, 6'h00, 1'b0, 1'b0, "sw2");
        drain();

        // Abort a load in ADDR; enables must drop without waiting for a clock.
        push(4'd1, 6'h23, 6'h00, 1'b0, 1'b0, "lw_abort");
        push(4'd2, 6'h23, 6'h00, 1'b0, 1'b0, "lw_abort");
        push(4'd3, 6'h23, 6'h00, 1'b0, 1'b0, "lw_abort");
        push(4'd8, 6'h23, 6'h00, 1'b0, 1'b0, "lw_abort");
        drain();
        #1 reset = 1'b1;
        #1;
        check("mid_reset/state", 32'(state), 32'd0);
        check("mid_reset/ctrl", 32'(dut_ctrl), 32'd0);
        @(negedge clk);
        #1;
        check("held_reset/state", 32'(state), 32'd0);
        reset = 1'b0;

        push_instr(6'h23, 6'h00, 1'b0, 1'b0, "lw_after_reset");
        push_instr(6'h00, 6'h20, 1'b0, 1'b0, "r_after_reset");
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
